mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and access sequencer for the shared byte-addressable data memory of the multicycle core. It accepts instruction-fetch and load/store requests, grants one at a time with round-robin or fixed priority, and latches the request onto the memory port. It flags misaligned accesses and suppresses them, then returns read data with a one-cycle acknowledge. It sits between the core's control FSM and the 256-word memory, which has a combinational read and writes on the clock edge.

## Interface
- FIXED_PRIO, 0, 0 = round-robin on simultaneous requests; 1 = data port always wins ties
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  instruction-fetch request; held until i_ack
- i_addr  in  32  fetch byte address; always word access, zero-extended
- i_ack  out  1  one-cycle pulse: fetch complete
- i_rdata  out  32  fetched word, valid while i_ack=1
- i_err  out  1  with i_ack: fetch was misaligned
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_mask  in  2  1x = word, 01 = halfword, 00 = byte
- d_signed  in  1  sign-extend sub-word loads
- d_wdata  in  32  store data; sub-word stores use the low bits
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  load result, valid while d_ack=1
- d_err  out  1  with d_ack: access was misaligned
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory byte address
- mem_mask  out  2  memory width mask, same encoding as d_mask
- mem_signed  out  1  memory sign-extend select
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_addr/mem_mask/mem_signed

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Reset: state=IDLE; last_grant=IFETCH.
  - All latched request registers are 0, so mem_addr=0, mem_mask=00, mem_signed=0 and mem_wdata=0.
  - mem_we, i_ack, d_ack, i_err and d_err are 0; i_rdata and d_rdata are 0.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one request: grant it.
- IDLE, both requests:
  - FIXED_PRIO=1: data wins.
  - FIXED_PRIO=0: grant the port not in last_grant.
  - Update last_grant on every grant.
- On grant, latch the request, compute err, go to ACCESS.
  - Latched fields: owner, addr, mask, signed, we, wdata.
  - A fetch latches mask=10, signed=0, we=0.
- Misalignment rule: err = (mask[1] & |addr[1:0]) | (mask==01 & addr[0]).
- ACCESS:
  - mem_addr, mem_mask, mem_signed and mem_wdata are driven from the latched values. They hold outside ACCESS too.
  - mem_we = latched_we & ~err, asserted only in this state.
  - Capture mem_rdata into the response register; capture 0 if err or we.
  - Go to RESP.
- RESP:
  - Assert the owner's ack, err and rdata for exactly one cycle.
  - The non-owner ack stays 0 and its rdata holds its last value.
  - Go to IDLE.
- Requester rule: deassert req in the cycle after ack. Any req seen in IDLE is a new request.
- Request inputs are ignored outside IDLE.
- Changing address or data while req is held before ack has no effect once the request is latched.

## Timing
- Request sampled at the rising edge ending cycle T.
- ACCESS in T+1; a store commits at the edge ending T+1.
- ack high in T+2; earliest next grant sampled at the edge ending T+3.
- Throughput: one access per 3 cycles; back-to-back alternating requests each complete every 3 cycles.
- mem_we is combinational from registered state: glitch-free and never high outside ACCESS.
- Reset asserted mid-operation:
  - state goes to IDLE immediately and mem_we drops asynchronously.
  - A pending ack is lost and never issued; an uncommitted store does not occur.
- Simultaneous requests with FIXED_PRIO=0 alternate grants: no starvation, worst-case wait is 1 access.

## Test plan
- Reset then a single fetch, i_addr=0x10 with memory word 4 = 0xDEADBEEF:
  - i_ack=1 exactly 2 cycles after the sampling edge, i_rdata=0xDEADBEEF, i_err=0.
  - d_ack stays 0 and mem_we never rises.
- Byte store then loads:
  - Store d_addr=0x23, d_mask=00, d_wdata=0x80.
  - Load the same byte with d_signed=1: d_rdata=0xFFFFFF80.
  - Load it with d_signed=0: d_rdata=0x00000080.
  - Word 8 shows only bits [31:24] changed.
- Misaligned accesses:
  - Halfword store d_addr=0x05: d_err=1, mem_we stays 0, memory unchanged, d_rdata=0.
  - Word fetch i_addr=0x02: i_err=1.
- i_req and d_req both held high for 4 grants, FIXED_PRIO=0:
  - grant order DATA, IFETCH, DATA, IFETCH.
  - With FIXED_PRIO=1 and d_req held continuously: all grants go to DATA.
- Store issued, rst_n pulsed low during ACCESS before the clock edge:
  - mem_we falls immediately and the target word is unchanged.
  - No ack is issued and state=IDLE after reset release.
- Req held one extra cycle past ack:
  - A second access to the same address is issued, with ack 3 cycles after the first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates instruction-fetch and load/store requests onto
// the shared data memory port of the multicycle core. One access is in
// flight at a time; each access takes IDLE -> ACCESS -> RESP (3 cycles).
//
// Handshake: a requester raises *_req and holds it (with stable fields)
// until it sees its one-cycle *_ack; it must drop *_req in the cycle after
// the ack, otherwise the still-high req is taken as a new request when the
// arbiter is back in IDLE. Requests are only sampled in IDLE, and the
// request fields are latched at grant, so later changes are ignored.
module mem_port_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_mask,
    input  logic        d_signed,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_mask,
    output logic        mem_signed,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Owner / last_grant encoding: 0 = instruction fetch, 1 = data port.
    localparam logic OWN_IFETCH = 1'b0;
    localparam logic OWN_DATA   = 1'b1;

    state_t      state, state_nxt;
    logic        last_grant;
    logic        owner;
    logic [31:0] lat_addr;
    logic [1:0]  lat_mask;
    logic        lat_signed;
    logic        lat_we;
    logic [31:0] lat_wdata;
    logic        lat_err;
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;

    logic        grant_valid;
    logic        grant_data;
    logic [31:0] req_addr;
    logic [1:0]  req_mask;
    logic        req_signed;
    logic        req_we;
    logic [31:0] req_wdata;
    logic        req_err;

    // Pick the winner and build the request that would be latched on grant.
    always_comb begin
        grant_valid = i_req | d_req;
        grant_data  = d_req;
        if (i_req && d_req) begin
            grant_data = FIXED_PRIO ? OWN_DATA : ~last_grant;
        end
        req_addr   = grant_data ? d_addr : i_addr;
        req_mask   = grant_data ? d_mask : 2'b10;
        req_signed = grant_data & d_signed;
        req_we     = grant_data & d_we;
        req_wdata  = grant_data ? d_wdata : 32'h0;
        req_err    = (req_mask[1] & (|req_addr[1:0])) |
                     ((req_mask == 2'b01) & req_addr[0]);
    end

    // Next-state: one pass through ACCESS and RESP per granted request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Latch the granted request and remember who won for round-robin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= OWN_IFETCH;
            owner      <= OWN_IFETCH;
            lat_addr   <= 32'h0;
            lat_mask   <= 2'b00;
            lat_signed <= 1'b0;
            lat_we     <= 1'b0;
            lat_wdata  <= 32'h0;
            lat_err    <= 1'b0;
        end else if (state == IDLE && grant_valid) begin
            last_grant <= grant_data;
            owner      <= grant_data;
            lat_addr   <= req_addr;
            lat_mask   <= req_mask;
            lat_signed <= req_signed;
            lat_we     <= req_we;
            lat_wdata  <= req_wdata;
            lat_err    <= req_err;
        end
    end

    // Capture read data for the owner; stores and faulted accesses return 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
        end else if (state == ACCESS) begin
            if (owner == OWN_DATA) d_rdata_q <= (lat_err | lat_we) ? 32'h0 : mem_rdata;
            else                   i_rdata_q <= (lat_err | lat_we) ? 32'h0 : mem_rdata;
        end
    end

    // Memory port and acks decode straight from registered state, so the
    // write strobe cannot glitch and vanishes the moment reset hits.
    always_comb begin
        mem_we     = (state == ACCESS) & lat_we & ~lat_err;
        mem_addr   = lat_addr;
        mem_mask   = lat_mask;
        mem_signed = lat_signed;
        mem_wdata  = lat_wdata;
        i_ack      = (state == RESP) & (owner == OWN_IFETCH);
        d_ack      = (state == RESP) & (owner == OWN_DATA);
        i_err      = i_ack & lat_err;
        d_err      = d_ack & lat_err;
        i_rdata    = i_rdata_q;
        d_rdata    = d_rdata_q;
        dbg_state  = state;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: bench for mem_port_arbiter with a 256-word
// byte-addressable memory model (combinational read, write on the edge).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, d_signed;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_mask;
  logic        i_ack, i_err, d_ack, d_err, mem_we, mem_signed;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_mask, dbg_state;

  // second instance with fixed priority; memory returns an address echo
  logic        fp_i_req, fp_d_req;
  logic        fp_i_ack, fp_i_err, fp_d_ack, fp_d_err, fp_mem_we, fp_mem_signed;
  logic [31:0] fp_i_rdata, fp_d_rdata, fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
  logic [1:0]  fp_mem_mask, fp_dbg_state;

  logic [31:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;
  int          we_cnt = 0;

  logic [33:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_mask(d_mask), .d_signed(d_signed),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_signed(mem_signed),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  mem_port_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .i_req(fp_i_req), .i_addr(32'h0000_0080), .i_ack(fp_i_ack), .i_rdata(fp_i_rdata),
    .i_err(fp_i_err),
    .d_req(fp_d_req), .d_we(1'b0), .d_addr(32'h0000_0040), .d_mask(2'b10),
    .d_signed(1'b0), .d_wdata(32'h0), .d_ack(fp_d_ack), .d_rdata(fp_d_rdata),
    .d_err(fp_d_err),
    .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_mask(fp_mem_mask),
    .mem_signed(fp_mem_signed), .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata),
    .dbg_state(fp_dbg_state)
  );

  assign fp_mem_rdata = fp_mem_addr ^ 32'hA5A5_0000;

  function automatic logic [31:0] mem_read(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] mask, input logic sgn);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    if (mask[1])            return w;
    else if (mask == 2'b01) return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
    else                    return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
  endfunction

  function automatic logic [31:0] mem_merge(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] mask, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    if (mask[1])            r = wd;
    else if (mask == 2'b01) begin
      if (off[1]) r[31:16] = wd[15:0];
      else        r[15:0]  = wd[15:0];
    end else begin
      case (off)
        2'd0: r[7:0]   = wd[7:0];
        2'd1: r[15:8]  = wd[7:0];
        2'd2: r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end
    return r;
  endfunction

  always_comb mem_rdata = mem_read(mem[mem_addr[9:2]], mem_addr[1:0], mem_mask, mem_signed);

  // memory writes: DUT stores plus bench backdoor preloads
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_merge(mem[mem_addr[9:2]], mem_addr[1:0], mem_mask, mem_wdata);
    if (bd_we)  mem[bd_idx] <= bd_data;
  end

  always @(negedge clk) if (mem_we) we_cnt <= we_cnt + 1;

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    bd_idx = idx; bd_data = data; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; fp_i_req = 1'b0; fp_d_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // waits for either ack of the main DUT; n = edges waited, -1 on timeout
  task automatic wait_ack(input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (i_ack || d_ack) begin
        n = k;
        return;
      end
    end
  endtask

  task automatic drive_data(input logic we, input logic [31:0] addr, input logic [1:0] mask,
                            input logic sgn, input logic [31:0] wd);
    @(posedge clk); #1;
    d_we = we; d_addr = addr; d_mask = mask; d_signed = sgn; d_wdata = wd; d_req = 1'b1;
  endtask

  task automatic drive_fetch(input logic [31:0] addr);
    @(posedge clk); #1;
    i_addr = addr; i_req = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({i_ack, d_ack, i_err, d_err, mem_we} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 00000", {i_ack, d_ack, i_err, d_err, mem_we});
    end
    n_cmp++;
    if ({mem_addr, mem_mask, mem_signed, mem_wdata} !== 67'h0) begin
      n_bad++; $display("FAIL reset_mem_port: got %h/%b/%b/%h expected zeros", mem_addr, mem_mask, mem_signed, mem_wdata);
    end
    n_cmp++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h %h expected 0 0", i_rdata, d_rdata);
    end
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_bad++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
  endtask

  task automatic test_single_fetch();
    int n, we0;
    logic [33:0] e, obs;
    we0 = we_cnt;
    drive_fetch(32'h0000_0010);
    exp_q.push_back({1'b0, 1'b0, 32'hDEADBEEF});
    wait_ack(10, n);
    i_req = 1'b0;
    n_cmp++;
    if (n !== 2) begin n_bad++; $display("FAIL fetch_latency: got %0d expected 2", n); end
    n_cmp++;
    if (d_ack !== 1'b0) begin n_bad++; $display("FAIL fetch_d_ack: got %b expected 0", d_ack); end
    obs = {1'b0, i_err, i_rdata};
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL fetch_resp: got %h expected %h", obs, e); end
    n_cmp++;
    if (we_cnt !== we0) begin n_bad++; $display("FAIL fetch_mem_we: got %0d writes expected 0", we_cnt - we0); end
  endtask

  task automatic test_byte_store_load();
    int n;
    logic [33:0] e, obs;
    logic [31:0] ld [3];
    logic        st [3];
    ld[0] = 32'h0; ld[1] = 32'hFFFF_FF80; ld[2] = 32'h0000_0080;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) drive_data(1'b1, 32'h23, 2'b00, 1'b0, 32'h0000_0080);
      else        drive_data(1'b0, 32'h23, 2'b00, (k == 1), 32'h0);
      exp_q.push_back({1'b1, 1'b0, ld[k]});
      wait_ack(10, n);
      d_req = 1'b0;
      n_cmp++;
      if (n !== 2 || i_ack !== 1'b0) begin
        n_bad++; $display("FAIL byte_ack_%0d: got n=%0d i_ack=%b expected n=2 i_ack=0", k, n, i_ack);
      end
      obs = {d_ack, d_err, d_rdata};
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL byte_resp_%0d: got %h expected %h", k, obs, e); end
      st[k] = 1'b0;
    end
    n_cmp++;
    if (mem[8] !== 32'h8022_3344) begin
      n_bad++; $display("FAIL byte_store_word8: got %h expected 80223344", mem[8]);
    end
  endtask

  task automatic test_misaligned();
    int n, we0;
    logic [33:0] e, obs;
    logic [31:0] a [5];
    logic [1:0]  m [5];
    logic        w [5];
    logic [33:0] x [5];
    // store half @5 (bad), load half @6 signed (ok), half @3 (bad),
    // word @0xE (bad), fetch @2 (bad)
    a[0] = 32'h05; m[0] = 2'b01; w[0] = 1'b1; x[0] = {1'b1, 1'b1, 32'h0};
    a[1] = 32'h06; m[1] = 2'b01; w[1] = 1'b0; x[1] = {1'b1, 1'b0, 32'hFFFF_CAFE};
    a[2] = 32'h03; m[2] = 2'b01; w[2] = 1'b0; x[2] = {1'b1, 1'b1, 32'h0};
    a[3] = 32'h0E; m[3] = 2'b10; w[3] = 1'b0; x[3] = {1'b1, 1'b1, 32'h0};
    a[4] = 32'h02; m[4] = 2'b10; w[4] = 1'b0; x[4] = {1'b0, 1'b1, 32'h0};
    we0 = we_cnt;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive_data(w[k], a[k], m[k], 1'b1, 32'h0000_BEEF);
      else       drive_fetch(a[k]);
      exp_q.push_back(x[k]);
      wait_ack(10, n);
      d_req = 1'b0; i_req = 1'b0;
      n_cmp++;
      if (n !== 2) begin n_bad++; $display("FAIL mis_latency_%0d: got %0d expected 2", k, n); end
      obs = d_ack ? {1'b1, d_err, d_rdata} : {1'b0, i_err, i_rdata};
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL mis_resp_%0d: got %h expected %h", k, obs, e); end
    end
    n_cmp++;
    if (we_cnt !== we0 || mem[1] !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL mis_no_write: got writes=%0d word1=%h expected 0 cafef00d", we_cnt - we0, mem[1]);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic [33:0] e, obs;
    apply_reset();
    d_we = 1'b0; d_addr = 32'h10; d_mask = 2'b10; d_signed = 1'b0;
    i_addr = 32'h20;
    for (int k = 0; k < 4; k++)
      exp_q.push_back((k % 2 == 0) ? {1'b1, 1'b0, 32'hDEADBEEF} : {1'b0, 1'b0, 32'h8022_3344});
    d_req = 1'b1; i_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(10, n);
      if (k == 3) begin d_req = 1'b0; i_req = 1'b0; end
      n_cmp++;
      if (n !== ((k == 0) ? 2 : 3) || (i_ack && d_ack)) begin
        n_bad++; $display("FAIL rr_spacing_%0d: got n=%0d acks=%b%b expected n=%0d one ack", k, n, i_ack, d_ack, (k == 0) ? 2 : 3);
      end
      obs = d_ack ? {1'b1, d_err, d_rdata} : {1'b0, i_err, i_rdata};
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL rr_grant_%0d: got %h expected %h", k, obs, e); end
    end
  endtask

  task automatic test_fixed_prio();
    int n;
    @(posedge clk); #1;
    fp_d_req = 1'b1; fp_i_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = -1;
      for (int c = 1; c <= 10; c++) begin
        @(posedge clk); #1;
        if (fp_i_ack || fp_d_ack) begin n = c; break; end
      end
      if (k == 3) begin fp_d_req = 1'b0; fp_i_req = 1'b0; end
      n_cmp++;
      if (n < 0 || fp_d_ack !== 1'b1 || fp_i_ack !== 1'b0 || fp_d_rdata !== 32'hA5A5_0040) begin
        n_bad++;
        $display("FAIL fp_grant_%0d: got n=%0d d_ack=%b i_ack=%b rdata=%h expected d_ack=1 i_ack=0 rdata=a5a50040", k, n, fp_d_ack, fp_i_ack, fp_d_rdata);
      end
    end
    // the starved fetch is served once data lets go
    fp_i_req = 1'b1;
    n = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (fp_i_ack || fp_d_ack) begin n = c; break; end
    end
    fp_i_req = 1'b0;
    n_cmp++;
    if (n < 0 || fp_i_ack !== 1'b1 || fp_i_rdata !== 32'hA5A5_0080) begin
      n_bad++; $display("FAIL fp_fetch_after: got n=%0d i_ack=%b rdata=%h expected i_ack=1 rdata=a5a50080", n, fp_i_ack, fp_i_rdata);
    end
  endtask

  task automatic test_reset_mid_store();
    int acks;
    drive_data(1'b1, 32'h30, 2'b10, 1'b0, 32'h0102_0304);
    @(posedge clk); #1;
    d_req = 1'b0;
    n_cmp++;
    if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rst_store_we_before: got %b expected 1", mem_we); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || dbg_state !== 2'd0) begin
      n_bad++; $display("FAIL rst_async: got we=%b state=%0d expected we=0 state=0", mem_we, dbg_state);
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (i_ack || d_ack) acks++;
    end
    n_cmp++;
    if (acks !== 0 || dbg_state !== 2'd0) begin
      n_bad++; $display("FAIL rst_no_ack: got acks=%0d state=%0d expected 0 0", acks, dbg_state);
    end
    n_cmp++;
    if (mem[12] !== 32'h5566_7788) begin
      n_bad++; $display("FAIL rst_no_commit: got %h expected 55667788", mem[12]);
    end
  endtask

  task automatic test_back_to_back();
    int n, acks;
    logic [33:0] e, obs;
    drive_data(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    exp_q.push_back({1'b1, 1'b0, 32'hDEADBEEF});
    exp_q.push_back({1'b1, 1'b0, 32'hDEADBEEF});
    wait_ack(10, n);
    n_cmp++;
    if (n !== 2) begin n_bad++; $display("FAIL b2b_first: got %0d expected 2", n); end
    obs = {d_ack, d_err, d_rdata};
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL b2b_resp0: got %h expected %h", obs, e); end
    // req stays high into the following IDLE cycle -> second access
    wait_ack(10, n);
    d_req = 1'b0;
    n_cmp++;
    if (n !== 3) begin n_bad++; $display("FAIL b2b_second: got %0d expected 3", n); end
    obs = {d_ack, d_err, d_rdata};
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL b2b_resp1: got %h expected %h", obs, e); end
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (i_ack || d_ack) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin n_bad++; $display("FAIL b2b_no_third: got %0d acks expected 0", acks); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bd_we = 1'b0; bd_idx = 8'h0; bd_data = 32'h0;
    rst_n = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_mask = 2'b10; d_signed = 1'b0;
    d_wdata = 32'h0; fp_i_req = 1'b0; fp_d_req = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    poke(8'd1,  32'hCAFE_F00D);
    poke(8'd4,  32'hDEADBEEF);
    poke(8'd8,  32'h1122_3344);
    poke(8'd12, 32'h5566_7788);
    test_reset();
    test_single_fetch();
    test_byte_store_load();
    test_misaligned();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid_store();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
